// File: rtl/wfg_wishbone_master_pkg.sv
// Shared types for the wfg Wishbone single-transfer initiator.
// The response bundle carries WB_DAT_W-bit data (BUSW must not exceed it).
package wfg_wishbone_master_pkg;

  localparam int unsigned TIMEOUT_W = 8;
  localparam int unsigned WB_DAT_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } wb_master_state_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic                err;
  } wb_master_rsp_t;

endpackage

// File: rtl/wfg_wishbone_master_timeout.sv
// Ack-wait counter for wfg_wishbone_master.
// Built only when WFG_WB_MASTER_TIMEOUT_EN is defined.
module wfg_wishbone_master_timeout
  import wfg_wishbone_master_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the cycle whose increment would reach LIMIT.
  assign expired = enable &&
                   (cnt_q == TIMEOUT_W'(LIMIT - 1));

endmodule

// File: rtl/wfg_wishbone_master.sv
// Wishbone classic single-transfer initiator (IDLE/BUS/RESP).
// Optional ack timeout: define WFG_WB_MASTER_TIMEOUT_EN.
module wfg_wishbone_master
  import wfg_wishbone_master_pkg::*;
#(
  parameter int unsigned BUSW           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUSW-1:0]   cmd_adr_i,
  input  logic [BUSW-1:0]   cmd_dat_i,
  input  logic [BUSW/8-1:0] cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [BUSW-1:0]   wbm_dat_i
);

  localparam int unsigned SELW = BUSW / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
      BUSW > WB_DAT_W || BUSW % 8 != 0) begin : g_bad_cfg
    $error("wfg_wishbone_master: bad parameters");
  end

  wb_master_state_t  state_q, state_d;
  wb_master_rsp_t    rsp_q, rsp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [BUSW-1:0]   adr_q, adr_d;
  logic [BUSW-1:0]   dat_q, dat_d;
  logic              to_expired;

`ifdef WFG_WB_MASTER_TIMEOUT_EN
  wfg_wishbone_master_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .clear   (state_q != BUS),
    .enable  (state_q == BUS && !wbm_ack_i),
    .expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack outranks a timeout landing in the same cycle.
        if (wbm_ack_i) begin
          rsp_d.dat   = we_q ? '0 : WB_DAT_W'(wbm_dat_i);
          rsp_d.err   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = RESP;
        end else if (to_expired) begin
          rsp_d.dat   = '0;
          rsp_d.err   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE) && !wb_rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = BUSW'(rsp_q.dat);
  assign rsp_err_o   = rsp_q.err;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wfg_wishbone_master.sv
// Directed bench for wfg_wishbone_master with a small register slave.
// Timeout scenario runs only with WFG_WB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_wfg_wishbone_master;

`ifdef WFG_WB_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 5;
`else
  localparam int unsigned TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [4];
  logic        ack_q = 1'b0;
  logic        ack_en = 1'b1;
  logic        comb_ack = 1'b0;
  logic        stray = 1'b0;
  int          ncyc = 0;
  int          acc_q[$];

  always #5 clk = ~clk;

  wfg_wishbone_master #(
    .BUSW(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (wdat),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (rdat)
  );

  // Register slave: registered ack by default, combinational when comb_ack.
  assign ack  = (comb_ack ? (cyc && stb && ack_en) : ack_q) | stray;
  assign rdat = mem[adr[3:2]];

  always @(posedge clk) begin
    if (!comb_ack && ack_en && cyc && stb && !ack_q) begin
      ack_q <= 1'b1;
      if (we)
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem[adr[3:2]][8*b +: 8] <= wdat[8*b +: 8];
    end else begin
      ack_q <= 1'b0;
    end
    if (comb_ack && ack_en && cyc && stb && we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem[adr[3:2]][8*b +: 8] <= wdat[8*b +: 8];
  end

  always @(negedge clk) begin
    ncyc++;
    if (cmd_valid && cmd_ready && !rst) acc_q.push_back(ncyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%b exp=0", cmd_ready);
    end
    total++;
    if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b0) begin
      bad++;
      $display("FAIL rst_ctl got=%b exp=00000",
               {cyc, stb, we, rsp_valid, rsp_err});
    end
    total++;
    if ({rsp_dat, adr, wdat, sel} !== 100'b0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h/%h exp=0",
               rsp_dat, adr, wdat, sel);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready_after got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h4;
    cmd_dat   = 32'h00AB_CD12;
    cmd_sel   = 4'hF;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({cyc, stb, we, cmd_ready} !== 4'b1110) begin
      bad++;
      $display("FAIL wr_bus got=%b exp=1110", {cyc, stb, we, cmd_ready});
    end
    total++;
    if (adr !== 32'h4 || wdat !== 32'h00AB_CD12 || sel !== 4'hF) begin
      bad++; $display("FAIL wr_fields got=%h/%h/%h exp=4/00abcd12/f",
                      adr, wdat, sel);
    end
    tick();
    total++;
    if (cyc !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL wr_e2 got=%b%b exp=10", cyc, rsp_valid);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || cyc !== 1'b0) begin
      bad++; $display("FAIL wr_e3 got=%b%b exp=10", rsp_valid, cyc);
    end
    total++;
    if (rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL wr_rsp got=%h/%b exp=0/0", rsp_dat, rsp_err);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL wr_done got=%b%b exp=01", rsp_valid, cmd_ready);
    end
    total++;
    if (mem[1][23:8] !== 16'hABCD || mem[1][7:0] !== 8'h12) begin
      bad++; $display("FAIL wr_cfg got=%h/%h exp=abcd/12",
                      mem[1][23:8], mem[1][7:0]);
    end
  endtask

  task automatic test_read();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h4;
    cmd_dat   = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rd_e2 got=%b exp=0", rsp_valid);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h00AB_CD12) begin
      bad++; $display("FAIL rd_e3 got=%b/%h exp=1/00abcd12",
                      rsp_valid, rsp_dat);
    end
    tick();
  endtask

  task automatic test_stray_idle();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    total++;
    if (cyc !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL stray_idle got=%b%b%b exp=001",
                      cyc, rsp_valid, cmd_ready);
    end
    total++;
    if (rsp_dat !== 32'h00AB_CD12) begin
      bad++; $display("FAIL stray_idle_dat got=%h exp=00abcd12", rsp_dat);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    tick();
    cmd_we    = 1'b1;
    cmd_adr   = 32'h8;
    cmd_dat   = 32'h1122_3344;
    tick();
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'hC0FF_EE01) begin
      bad++; $display("FAIL bp_rsp got=%b/%h exp=1/c0ffee01",
                      rsp_valid, rsp_dat);
    end
    for (int i = 0; i < 10; i++) begin
      stray = (i == 3);
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'hC0FF_EE01 ||
          rsp_err !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/c0ffee01/0",
                        i, rsp_valid, rsp_dat, rsp_err);
      end
      total++;
      if (cmd_ready !== 1'b0 || cyc !== 1'b0) begin
        bad++; $display("FAIL bp_block%0d got=%b%b exp=00",
                        i, cmd_ready, cyc);
      end
    end
    stray = 1'b0;
    rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin
      bad++; $display("FAIL bp_hs got=%b%b%b exp=010",
                      rsp_valid, cmd_ready, cyc);
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if (cyc !== 1'b1 || we !== 1'b1 || adr !== 32'h8) begin
      bad++; $display("FAIL bp_second got=%b%b/%h exp=11/8", cyc, we, adr);
    end
    tick();
    tick();
    tick();
    total++;
    if (mem[2] !== 32'h1122_3344) begin
      bad++; $display("FAIL bp_mem got=%h exp=11223344", mem[2]);
    end
  endtask

  task automatic test_back_to_back();
    acc_q.delete();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h4;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_q.size() >= 2) break;
    end
    cmd_valid = 1'b0;
    total++;
    if (acc_q.size() < 2) begin
      bad++; $display("FAIL b2b_timeout got=%0d exp=2", acc_q.size());
    end else begin
      total++;
      if (acc_q[1] - acc_q[0] != 4) begin
        bad++; $display("FAIL b2b_gap got=%0d exp=4", acc_q[1] - acc_q[0]);
      end
    end
    repeat (4) tick();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_drain got=%b%b exp=01", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_comb_ack();
    comb_ack  = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    tick();
    cmd_valid = 1'b0;
    total++;
    if (cyc !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL comb_e1 got=%b%b exp=10", cyc, rsp_valid);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || cyc !== 1'b0 || rsp_dat !== 32'hC0FF_EE01) begin
      bad++; $display("FAIL comb_e2 got=%b%b/%h exp=10/c0ffee01",
                      rsp_valid, cyc, rsp_dat);
    end
    tick();
    comb_ack = 1'b0;
  endtask

  task automatic test_reset_in_bus();
    ack_en    = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h4;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (cyc !== 1'b1) begin
      bad++; $display("FAIL rib_bus2 got=%b exp=1", cyc);
    end
    tick();
    total++;
    if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0 ||
        cmd_ready !== 1'b0) begin
      bad++; $display("FAIL rib_drop got=%b%b%b%b exp=0000",
                      cyc, stb, rsp_valid, cmd_ready);
    end
    rst = 1'b0;
    ack_en = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || rsp_dat !== 32'h0) begin
      bad++; $display("FAIL rib_after got=%b/%h exp=1/0", cmd_ready, rsp_dat);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b0 || cyc !== 1'b0) begin
        bad++; $display("FAIL rib_norsp%0d got=%b%b exp=00",
                        i, rsp_valid, cyc);
      end
    end
  endtask

`ifdef WFG_WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    ack_en    = 1'b0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'hC;
    cmd_dat   = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (cyc === 1'b1) n++;
      tick();
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL to_norsp got=0 exp=1");
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL to_cyc_len got=%0d exp=5", n);
    end
    total++;
    if (rsp_err !== 1'b1 || rsp_dat !== 32'h0 || cyc !== 1'b0) begin
      bad++; $display("FAIL to_rsp got=%b/%h/%b exp=1/0/0",
                      rsp_err, rsp_dat, cyc);
    end
    rsp_ready = 1'b1;
    ack_en = 1'b1;
    tick();
    tick();
  endtask
`endif

  initial begin
    mem[0] = 32'hC0FF_EE01;
    mem[1] = 32'h0;
    mem[2] = 32'h5555_AAAA;
    mem[3] = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_stray_idle();
    test_backpressure();
    test_back_to_back();
    test_comb_ack();
    test_reset_in_bus();
`ifdef WFG_WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wfg_wishbone_master.md
# wfg_wishbone_master

Wishbone classic single-transfer initiator for the waveform-generator control path. Accepts register read/write commands on a valid/ready command port, drives one Wishbone cycle per command toward the `wfg_*` register slaves, and returns read data or error status on a valid/ready response port. Used by on-chip sequencers and test harnesses to program `wfg_core` and sibling blocks without a CPU.

## Interface
Parameters:
- `BUSW`, 32, data and address width; `BUSW/8` select lanes.
- `TIMEOUT_CYCLES`, 16, bus cycles to wait for `wbm_ack_i` before aborting. Used only with the timeout feature compiled in. Range 1..255.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  synchronous active-high reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  BUSW  target address.
- `cmd_dat_i`  in  BUSW  write data.
- `cmd_sel_i`  in  BUSW/8  byte selects.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed when high with `rsp_valid_o`.
- `rsp_dat_o`  out  BUSW  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  transfer timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1  Wishbone cycle, strobe, write enable.
- `wbm_sel_o`  out  BUSW/8; `wbm_adr_o`, `wbm_dat_o`  out  BUSW  latched command fields.
- `wbm_ack_i`  in  1; `wbm_dat_i`  in  BUSW  slave acknowledge and read data.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: `cmd_ready_o` = 1. On `cmd_valid_i`, latch `we/adr/dat/sel` into the `wbm_*` registers, assert `wbm_cyc_o` and `wbm_stb_o`, and go to BUS.
- BUS: `cmd_ready_o` = 0, and `wbm_*` outputs are held stable. On `wbm_ack_i`:
  - capture `rsp_dat_o` = `wbm_dat_i` if read, otherwise 0;
  - set `rsp_err_o` = 0;
  - deassert `cyc/stb` and assert `rsp_valid_o`;
  - go to RESP.
- RESP: hold `rsp_*` stable until `rsp_ready_i`, then clear `rsp_valid_o` and go to IDLE. Commands are not accepted in RESP, so there is no overlap.
- `wbm_ack_i` is ignored outside BUS. Slaves with a registered ack may pulse ack one cycle after `stb` drops.
- Reset values of outputs:
  - `cmd_ready_o` = 0 while reset is asserted, 1 in the first cycle after reset.
  - `rsp_valid_o`, `rsp_err_o`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0.
  - `rsp_dat_o`, `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o` = 0.
- Reset during BUS or RESP: `cyc/stb` drop at that edge, any pending response is discarded, and the FSM returns to IDLE.

## Timing
- All outputs are registered except `cmd_ready_o`, which is decoded from state: `state == IDLE && !wb_rst_i`.
- Command accepted at edge E → `cyc/stb` high from cycle E+1.
- Against a registered-ack slave: ack is seen in cycle E+2, `rsp_valid_o` goes high in cycle E+3, and `cyc/stb` go low in cycle E+3.
- Minimum command-to-command spacing is 4 cycles when `rsp_ready_i` is tied high.
- Ack in the first BUS cycle (combinational slave) is legal: `rsp_valid_o` goes high in cycle E+2.

## Configuration
- Macro: `WFG_WB_MASTER_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on BUS entry and increments each BUS cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, `cyc/stb` drop and the FSM goes to RESP with `rsp_err_o` = 1 and `rsp_dat_o` = 0.
  - Ack and timeout in the same cycle: ack wins, and `rsp_err_o` = 0.
- Not defined: BUS waits indefinitely for ack, `rsp_err_o` is tied 0, and the counter is not built.

## Structure
- Package `wfg_wishbone_master_pkg` holds:
  - state enum typedef `wb_master_state_t` (IDLE, BUS, RESP);
  - response struct `wb_master_rsp_t` (`dat`, `err`);
  - constant `TIMEOUT_W` = 8.
- Sub-module `wfg_wishbone_master_timeout` holds the timeout counter. Inputs: clear, enable. Output: expired. It is instantiated only under `WFG_WB_MASTER_TIMEOUT_EN`.

## Test plan
- Write `0x4`, data `0x00ABCD12`, sel `0xF`, to `wfg_core_wishbone_reg` → `cfg_subcycle_q_o` = `0xABCD`, `cfg_sync_q_o` = `0x12`; response has `rsp_dat_o` = 0 and `rsp_err_o` = 0.
- Read `0x4` after the above write → `rsp_dat_o` = `0x00ABCD12` in cycle E+3 relative to acceptance.
- Hold `rsp_ready_i` low for 10 cycles after a read → `rsp_*` stable throughout, `cmd_ready_o` = 0, and a second `cmd_valid_i` is not accepted until after the response handshake.
- Reset asserted in the second BUS cycle → `wbm_cyc_o` = 0 next cycle, no response is issued, and `cmd_ready_o` = 1 in the first cycle after reset.
- With `WFG_WB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 5, slave never acks → `cyc` high for exactly 5 cycles, then `rsp_err_o` = 1 and `rsp_dat_o` = 0.
- Stray `wbm_ack_i` pulse in IDLE and RESP → no state change, and response data is unchanged.
